bundle_queue: RTL and testbench
===============================

Name: bundle_queue

Overview:
- Parametrised successor to the single-bundle advance logic.
- Buffers up to DEPTH fetched instruction bundles between the I-cache and the queue/issue stage.
- Tracks a per-slot valid mask for the head bundle and retires the head once every valid slot is taken.
- Generates `next` to advance the fetch PC whenever a bundle can be accepted.

Parameters:
- QSLOTS, `QSLOTS (4): slots per bundle.
- DEPTH, 4: bundle entries; power of two, 2..16.
- BUNDLE_WIDTH, 128: bits per bundle.
- AMSB, 31: MSB of the fetch address.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- phit  in  1  I-cache hit; bundle_i, pc_i and slotv_i are valid.
- bundle_i  in  BUNDLE_WIDTH  fetched bundle.
- pc_i  in  AMSB+1  address of bundle_i.
- slotv_i  in  QSLOTS  slots valid in bundle_i (from template/stop decode).
- take  in  QSLOTS  head slots consumed by issue this cycle.
- flush  in  1  branch miss / exception; discard all buffered bundles.
- next  out  1  fetch PC advance; bundle_i accepted this cycle.
- head_v  out  1  head entry valid.
- head_bundle  out  BUNDLE_WIDTH  head bundle.
- head_pc  out  AMSB+1  head address.
- head_slotv  out  QSLOTS  remaining un-taken slots of head.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Storage: circular buffer; rd/wr pointers $clog2(DEPTH) bits, wrap modulo DEPTH; count held separately, 0..DEPTH.
- head_bundle, head_pc and head_slotv are combinational reads of entry[rd]; each entry stores its own remaining-slot mask.
- Reset: count=0, rd=wr=0, all entry masks 0, head_v=0, head_slotv=0. `next`=1 while rst is high; no enqueue, no dequeue.
- Clear condition: clr = head_v && ((head_slotv & ~take) == 0).
  - take bits where head_slotv is 0 are ignored.
  - take with head_v=0 is ignored.
- Partial take: head_slotv <= head_slotv & ~take, registered, visible next cycle.
- Pop: on clr, rd advances and count decrements.
- Accept: next = phit && !flush && (count < DEPTH || clr).
  - A full queue accepts in the same cycle as a pop.
  - Combinational path: phit/take/flush -> next. No latency on `next`.
- Enqueue on next with slotv_i != 0: write entry[wr] = {bundle_i, pc_i, slotv_i}, advance wr, increment count.
- next with slotv_i == 0: bundle is dropped; PC still advances; no entry written. Empty bundles never occupy the queue.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty queue: head_v=1 the following cycle; no bypass of bundle_i to head.
- flush: count=0, rd=wr=0, all masks cleared at the clock edge; take and phit ignored that cycle; next=0 that cycle.
- rst has priority over flush; flush has priority over push/pop.
- Invariant: count never exceeds DEPTH and never underflows; a bench assertion checks both.

Optional Feature:
- BUNDLEQ_PERF_EN defined:
  - Adds output stall_cnt [31:0] and output empty_cnt [31:0].
  - stall_cnt increments each cycle phit=1 and next=0 with flush=0 (queue full, no pop).
  - empty_cnt increments each cycle head_v=0 and rst=0.
  - Both counters clear on rst only (not on flush) and saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
- Fill: rst 2 cycles; then phit=1, slotv_i=4'b1111, take=0 for 6 cycles -> next=1 for cycles 1-4, 0 for cycles 5-6; count=4; stall_cnt=2 (PERF_EN).
- Partial take: head_slotv=4'b1111; take=4'b0011 -> head_slotv=4'b1100; take=4'b0100 -> 4'b1000; take=4'b1000 -> pop, count 4->3, head_pc = second pc_i.
- Full plus same-cycle pop: count=4, phit=1, take=head_slotv -> next=1, count stays 4, wr and rd both wrap to 0 correctly.
- Empty bundle: phit=1, slotv_i=4'b0000 on empty queue -> next=1, count stays 0, head_v stays 0.
- Flush: count=3, flush=1 with phit=1 and take=4'b1111 -> next=0; next cycle count=0, head_v=0, head_slotv=0.
- Reset mid-operation: count=2, rst=1 with phit=1 -> next=1, no enqueue; after release count=0, head_v=0.

Source files
------------

// File: rtl/bundle_queue.sv
//------------------------------------------------------------------------------
// bundle_queue
//
// Purpose:
//    Circular buffer of fetched instruction bundles that sits between the
//    I-cache and the issue stage. Each entry holds a bundle, its fetch address
//    and a mask of slots that have not yet been issued. The head entry is
//    retired once every one of its valid slots has been taken. The output
//    `next` tells the fetch unit to advance its PC because the bundle on
//    bundle_i was accepted. When slotv_i is zero, the bundle is accepted but
//    is not stored.
//
// Optional feature (macro BUNDLEQ_PERF_EN):
//    Adds two saturating performance counters, stall_cnt and empty_cnt.
//    rst clears them. flush does not clear them.
//
// Ports:
//    clk          in   system clock
//    rst          in   synchronous active-high reset
//    phit         in   I-cache hit; bundle_i, pc_i and slotv_i are valid
//    bundle_i     in   fetched bundle             [BUNDLE_WIDTH-1:0]
//    pc_i         in   address of bundle_i        [AMSB:0]
//    slotv_i      in   valid slots of bundle_i    [QSLOTS-1:0]
//    take         in   head slots issued this cycle [QSLOTS-1:0]
//    flush        in   discard every buffered bundle
//    next         out  bundle_i accepted; fetch PC advances
//    head_v       out  head entry valid
//    head_bundle  out  head bundle
//    head_pc      out  head address
//    head_slotv   out  remaining un-taken slots of the head entry
//    count        out  number of occupied entries [$clog2(DEPTH):0]
//    stall_cnt    out  (BUNDLEQ_PERF_EN) cycles with a hit refused while full
//    empty_cnt    out  (BUNDLEQ_PERF_EN) cycles with an empty queue
//------------------------------------------------------------------------------
module bundle_queue #(
   parameter int QSLOTS       = 4,
   parameter int DEPTH        = 4,
   parameter int BUNDLE_WIDTH = 128,
   parameter int AMSB         = 31
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      phit,
   input  logic [BUNDLE_WIDTH-1:0]   bundle_i,
   input  logic [AMSB:0]             pc_i,
   input  logic [QSLOTS-1:0]         slotv_i,
   input  logic [QSLOTS-1:0]         take,
   input  logic                      flush,
   output logic                      next,
   output logic                      head_v,
   output logic [BUNDLE_WIDTH-1:0]   head_bundle,
   output logic [AMSB:0]             head_pc,
   output logic [QSLOTS-1:0]         head_slotv,
`ifdef BUNDLEQ_PERF_EN
   output logic [31:0]               stall_cnt,
   output logic [31:0]               empty_cnt,
`endif
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [BUNDLE_WIDTH-1:0] r_bundle [DEPTH];
   logic [AMSB:0]           r_pc     [DEPTH];
   logic [QSLOTS-1:0]       r_mask   [DEPTH];
   logic [PW-1:0]           r_rd;
   logic [PW-1:0]           r_wr;
   logic [CW-1:0]           r_count;

   logic w_clr;
   logic w_next;
   logic w_push;
   logic w_pop;

   // The head is read combinationally from the entry at the read pointer.
   // The queue never bypasses bundle_i to the head.
   assign head_v      = (r_count != '0);
   assign head_bundle = r_bundle[r_rd];
   assign head_pc     = r_pc[r_rd];
   assign head_slotv  = r_mask[r_rd];
   assign count       = r_count;

   // The head retires when this cycle's take covers every remaining slot.
   // A full queue can accept a new bundle in the same cycle as that pop,
   // because the pop frees an entry.
   // While rst is high, next is forced to 1, but nothing is enqueued.
   assign w_clr  = head_v && ((head_slotv & ~take) == '0);
   assign w_next = rst ? 1'b1
                       : (phit && !flush && ((r_count < CW'(DEPTH)) || w_clr));
   assign next   = w_next;
   assign w_push = w_next && !rst && (slotv_i != '0);
   assign w_pop  = w_clr && !rst && !flush;

   // Pointers, occupancy and remaining-slot masks.
   // rst has priority over flush, and flush has priority over push and pop.
   // The push mask assignment comes last. When the queue is full and pops
   // and pushes in the same cycle, the new entry overwrites the retiring one.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mask[i] <= '0;
         end
      end else begin
         if (w_pop) begin
            r_mask[r_rd] <= '0;
            r_rd         <= r_rd + 1'b1;
         end else if (head_v) begin
            r_mask[r_rd] <= head_slotv & ~take;
         end
         if (w_push) begin
            r_mask[r_wr] <= slotv_i;
            r_wr         <= r_wr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Bundle and address storage needs no reset.
   // An entry's content is only observed while its mask makes it valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_bundle[r_wr] <= bundle_i;
         r_pc[r_wr]     <= pc_i;
      end
   end

`ifdef BUNDLEQ_PERF_EN
   // Saturating performance counters. Only rst clears them.
   // A stall is a hit that was refused without a flush, which means the
   // queue was full and nothing popped. While rst is high, next is 1, so
   // stall_cnt never counts during reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         empty_cnt <= '0;
      end else begin
         if (phit && !w_next && !flush && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (!head_v && (empty_cnt != 32'hFFFF_FFFF)) begin
            empty_cnt <= empty_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bundle_queue.sv
//------------------------------------------------------------------------------
// tb_bundle_queue
//
// Self-checking bench for bundle_queue with the default parameters.
// A reference model built on a queue of entries predicts next and the
// head/count state. Directed steps come first, followed by a randomized run.
// Define BUNDLEQ_PERF_EN to also check the performance counters.
//------------------------------------------------------------------------------
module tb_bundle_queue;

   localparam int DEPTH = 4;

   typedef struct {
      logic [127:0] bundle;
      logic [31:0]  pc;
      logic [3:0]   mask;
   } entry_t;

   logic          clk;
   logic          rst;
   logic          phit;
   logic [127:0]  bundle_i;
   logic [31:0]   pc_i;
   logic [3:0]    slotv_i;
   logic [3:0]    take;
   logic          flush;
   logic          next;
   logic          head_v;
   logic [127:0]  head_bundle;
   logic [31:0]   head_pc;
   logic [3:0]    head_slotv;
   logic [2:0]    count;
`ifdef BUNDLEQ_PERF_EN
   logic [31:0]   stall_cnt;
   logic [31:0]   empty_cnt;
   int unsigned   mStall;
   int unsigned   mEmpty;
`endif

   entry_t        mq[$];
   int            nAsserts;
   int            nFails;

   bundle_queue #(
      .QSLOTS(4), .DEPTH(DEPTH), .BUNDLE_WIDTH(128), .AMSB(31)
   ) dut (
      .clk(clk),
      .rst(rst),
      .phit(phit),
      .bundle_i(bundle_i),
      .pc_i(pc_i),
      .slotv_i(slotv_i),
      .take(take),
      .flush(flush),
      .next(next),
      .head_v(head_v),
      .head_bundle(head_bundle),
      .head_pc(head_pc),
      .head_slotv(head_slotv),
`ifdef BUNDLEQ_PERF_EN
      .stall_cnt(stall_cnt),
      .empty_cnt(empty_cnt),
`endif
      .count(count)
   );

   // Free-running clock with a 10-time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point. Any mismatch is counted and reported.
   task automatic checkOutput(input string tag, input logic [159:0] observed,
                              input logic [159:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Run one clock cycle against the model:
   //   - drive the inputs after the falling edge;
   //   - check the combinational next;
   //   - advance the model at the rising edge;
   //   - check the registered state just after that edge.
   task automatic applyStimulus(input logic r, input logic f, input logic p,
                                input logic [3:0] sv, input logic [3:0] tk,
                                input logic [127:0] b, input logic [31:0] pc);
      logic   expNext;
      logic   headV;
      logic   clr;
      entry_t e;
      rst = r; flush = f; phit = p; slotv_i = sv; take = tk;
      bundle_i = b; pc_i = pc;
      headV   = (mq.size() > 0);
      clr     = headV && ((mq[0].mask & ~tk) == 4'b0000);
      expNext = r ? 1'b1 : (p && !f && ((mq.size() < DEPTH) || clr));
      #1;
      checkOutput("next", next, expNext);
      @(posedge clk);
`ifdef BUNDLEQ_PERF_EN
      if (r) begin
         mStall = 0;
         mEmpty = 0;
      end else begin
         if (p && !expNext && !f) mStall++;
         if (!headV) mEmpty++;
      end
`endif
      if (r || f) begin
         mq.delete();
      end else begin
         if (headV) begin
            if (clr) void'(mq.pop_front());
            else mq[0].mask = mq[0].mask & ~tk;
         end
         if (expNext && (sv != 4'b0000)) begin
            e.bundle = b; e.pc = pc; e.mask = sv;
            mq.push_back(e);
         end
      end
      #1;
      checkOutput("count", count, mq.size());
      checkOutput("count_bound", (count <= DEPTH), 1'b1);
      checkOutput("head_v", head_v, (mq.size() > 0));
      if (mq.size() > 0) begin
         checkOutput("head_slotv", head_slotv, mq[0].mask);
         checkOutput("head_pc", head_pc, mq[0].pc);
         checkOutput("head_bundle", head_bundle, mq[0].bundle);
      end else begin
         checkOutput("head_slotv_empty", head_slotv, 4'b0000);
      end
`ifdef BUNDLEQ_PERF_EN
      checkOutput("stall_cnt", stall_cnt, mStall);
      checkOutput("empty_cnt", empty_cnt, mEmpty);
`endif
      @(negedge clk);
   endtask

   function automatic logic [127:0] randBundle();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Run the directed steps, then the randomized run, then print the summary.
   initial begin
      logic [3:0]  tk;
      logic [3:0]  sv;
      nAsserts = 0;
      nFails   = 0;
`ifdef BUNDLEQ_PERF_EN
      mStall = 0;
      mEmpty = 0;
`endif
      rst = 1'b1; flush = 1'b0; phit = 1'b0; slotv_i = '0; take = '0;
      bundle_i = '0; pc_i = '0;
      @(negedge clk);

      // Reset for 2 cycles, then 6 cycles of hits with take=0 fill the queue.
      applyStimulus(1, 0, 0, 4'b0000, 4'b0000, '0, '0);
      applyStimulus(1, 0, 0, 4'b0000, 4'b0000, '0, '0);
      checkOutput("reset_count", count, 3'd0);
      checkOutput("reset_head_v", head_v, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 0, 1, 4'b1111, 4'b0000, randBundle(), 32'h1000 + 32'(i * 16));
      end
      checkOutput("fill_count", count, 3'd4);
`ifdef BUNDLEQ_PERF_EN
      checkOutput("fill_stall", stall_cnt, 32'd2);
`endif

      // Take the head's slots in three parts; the last take pops the head.
      checkOutput("pt_slotv0", head_slotv, 4'b1111);
      applyStimulus(0, 0, 0, 4'b0000, 4'b0011, '0, '0);
      checkOutput("pt_slotv1", head_slotv, 4'b1100);
      applyStimulus(0, 0, 0, 4'b0000, 4'b0100, '0, '0);
      checkOutput("pt_slotv2", head_slotv, 4'b1000);
      applyStimulus(0, 0, 0, 4'b0000, 4'b1000, '0, '0);
      checkOutput("pt_count", count, 3'd3);
      checkOutput("pt_head_pc", head_pc, 32'h1010);

      // Refill to full, then push and pop in the same cycle repeatedly,
      // so both pointers wrap.
      applyStimulus(0, 0, 1, 4'b0111, 4'b0000, randBundle(), 32'h2000);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 1, 4'b1111, head_slotv, randBundle(), 32'h3000 + 32'(i * 16));
         checkOutput("full_pop_count", count, 3'd4);
      end

      // Flush with hit and take asserted: next is 0 and the queue empties.
      applyStimulus(0, 0, 0, 4'b0000, head_slotv, '0, '0);
      checkOutput("pre_flush_count", count, 3'd3);
      applyStimulus(0, 1, 1, 4'b1111, 4'b1111, randBundle(), 32'h4000);
      checkOutput("flush_count", count, 3'd0);
      checkOutput("flush_slotv", head_slotv, 4'b0000);

      // An empty bundle on an empty queue advances the PC but is not stored.
      applyStimulus(0, 0, 1, 4'b0000, 4'b0000, randBundle(), 32'h5000);
      checkOutput("empty_bundle_count", count, 3'd0);
      checkOutput("empty_bundle_head_v", head_v, 1'b0);

      // Reset in the middle of operation: next=1, and nothing is enqueued.
      applyStimulus(0, 0, 1, 4'b0001, 4'b0000, randBundle(), 32'h6000);
      applyStimulus(0, 0, 1, 4'b0010, 4'b0000, randBundle(), 32'h6010);
      checkOutput("pre_rst_count", count, 3'd2);
      applyStimulus(1, 0, 1, 4'b1111, 4'b0000, randBundle(), 32'h6020);
      checkOutput("rst_mid_count", count, 3'd0);
      checkOutput("rst_mid_head_v", head_v, 1'b0);

      // Randomized run. take is usually related to the head mask, so that
      // pops and partial takes both occur often.
      for (int i = 0; i < 400; i++) begin
         sv = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
         case ($urandom_range(0, 3))
            0:       tk = 4'b0000;
            1:       tk = head_slotv;
            2:       tk = head_slotv & 4'($urandom);
            default: tk = 4'($urandom);
         endcase
         applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 24) == 0),
                       ($urandom_range(0, 3) != 0), sv, tk, randBundle(), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
